// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one external combinational ALU between two requesters. A round-robin
//   arbiter picks a requester in IDLE. The winner's operands are latched into
//   the ALU operand registers. After one settling cycle (EXEC), the ALU result
//   and flags are captured. They are held as a response for the winner (RESP)
//   until that requester takes them.
//
//   Optional feature, macro ALU_ARB_OPCHK_EN:
//     When defined, an accepted opcode outside 0..3 bypasses the ALU. The
//     response is an error response (Rsp_Err=1) delivered one cycle after
//     accept. When undefined, Rsp_Err is tied low.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   Req_Valid/Req_Ready  per-requester command handshake (bit i = requester i)
//   Req0_A/B/Op          requester 0 command
//   Req1_A/B/Op          requester 1 command
//   Rsp_Valid/Rsp_Ready  per-requester response handshake (one-hot or zero)
//   Rsp_Result/Zero/Carry/Err  captured response payload
//   Alu_A/Alu_B/Alu_OpCode     registered ALU inputs
//   Alu_Result/Zero/Carry      ALU outputs (combinational from Alu_* inputs)
//   Busy                 high whenever the FSM is not in IDLE
module alu_arbiter #(
  parameter int A_W  = 4,
  parameter int R_W  = 8,
  parameter int OP_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      Req_Valid,
  output logic [1:0]      Req_Ready,
  input  logic [A_W-1:0]  Req0_A,
  input  logic [A_W-1:0]  Req0_B,
  input  logic [OP_W-1:0] Req0_Op,
  input  logic [A_W-1:0]  Req1_A,
  input  logic [A_W-1:0]  Req1_B,
  input  logic [OP_W-1:0] Req1_Op,
  output logic [1:0]      Rsp_Valid,
  input  logic [1:0]      Rsp_Ready,
  output logic [R_W-1:0]  Rsp_Result,
  output logic            Rsp_Zero,
  output logic            Rsp_Carry,
  output logic            Rsp_Err,
  output logic [A_W-1:0]  Alu_A,
  output logic [A_W-1:0]  Alu_B,
  output logic [OP_W-1:0] Alu_OpCode,
  input  logic [R_W-1:0]  Alu_Result,
  input  logic            Alu_Zero,
  input  logic            Alu_Carry,
  output logic            Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q;
  logic            last_q;    // requester granted most recently
  logic            owner_q;   // requester the in-flight command belongs to
  logic [A_W-1:0]  alu_a_q;
  logic [A_W-1:0]  alu_b_q;
  logic [OP_W-1:0] alu_op_q;
  logic [R_W-1:0]  rsp_result_q;
  logic            rsp_zero_q;
  logic            rsp_carry_q;

  // Arbitration: a lone requester always wins; on a tie the one that did not
  // win last time gets the grant.
  logic            win;
  logic [A_W-1:0]  win_a;
  logic [A_W-1:0]  win_b;
  logic [OP_W-1:0] win_op;
  logic            accept;

  always_comb begin
    win = 1'b0;
    if (Req_Valid[0] && Req_Valid[1]) begin
      win = ~last_q;
    end else if (Req_Valid[1]) begin
      win = 1'b1;
    end
    win_a  = win ? Req1_A  : Req0_A;
    win_b  = win ? Req1_B  : Req0_B;
    win_op = win ? Req1_Op : Req0_Op;
  end

  // Ready is offered only to a winner that is actually requesting, and never
  // while reset is asserted.
  assign Req_Ready = (state_q == IDLE && !rst) ? ((2'b01 << win) & Req_Valid) : 2'b00;
  assign accept    = |Req_Ready;

`ifdef ALU_ARB_OPCHK_EN
  logic rsp_err_q;
  logic win_op_legal;

  assign win_op_legal = (win_op <= OP_W'(3));
  assign Rsp_Err      = rsp_err_q;
`else
  assign Rsp_Err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q <= win;
            last_q  <= win;
`ifdef ALU_ARB_OPCHK_EN
            if (!win_op_legal) begin
              // Illegal opcode: the ALU registers keep their old values and an
              // error response goes straight out.
              rsp_result_q <= '0;
              rsp_zero_q   <= 1'b0;
              rsp_carry_q  <= 1'b0;
              rsp_err_q    <= 1'b1;
              state_q      <= RESP;
            end else begin
              alu_a_q  <= win_a;
              alu_b_q  <= win_b;
              alu_op_q <= win_op;
              state_q  <= EXEC;
            end
`else
            alu_a_q  <= win_a;
            alu_b_q  <= win_b;
            alu_op_q <= win_op;
            state_q  <= EXEC;
`endif
          end
        end
        EXEC: begin
          // ALU has had a full cycle to settle from the operand registers.
          rsp_result_q <= Alu_Result;
          rsp_zero_q   <= Alu_Zero;
          rsp_carry_q  <= Alu_Carry;
`ifdef ALU_ARB_OPCHK_EN
          rsp_err_q    <= 1'b0;
`endif
          state_q      <= RESP;
        end
        RESP: begin
          // Only the owner's Rsp_Ready can retire the response.
          if (Rsp_Ready[owner_q]) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Rsp_Valid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign Rsp_Result = rsp_result_q;
  assign Rsp_Zero   = rsp_zero_q;
  assign Rsp_Carry  = rsp_carry_q;
  assign Alu_A      = alu_a_q;
  assign Alu_B      = alu_b_q;
  assign Alu_OpCode = alu_op_q;
  assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] Req_Valid;
  logic [1:0] Req_Ready;
  logic [3:0] Req0_A, Req0_B, Req1_A, Req1_B;
  logic [2:0] Req0_Op, Req1_Op;
  logic [1:0] Rsp_Valid;
  logic [1:0] Rsp_Ready;
  logic [7:0] Rsp_Result;
  logic       Rsp_Zero, Rsp_Carry, Rsp_Err;
  logic [3:0] Alu_A, Alu_B;
  logic [2:0] Alu_OpCode;
  logic [7:0] Alu_Result;
  logic       Alu_Zero, Alu_Carry;
  logic       Busy;

  int n_checks = 0;
  int n_pass   = 0;

  alu_arbiter #(.A_W(4), .R_W(8), .OP_W(3)) dut (
    .clk(clk), .rst(rst),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Req0_A(Req0_A), .Req0_B(Req0_B), .Req0_Op(Req0_Op),
    .Req1_A(Req1_A), .Req1_B(Req1_B), .Req1_Op(Req1_Op),
    .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready),
    .Rsp_Result(Rsp_Result), .Rsp_Zero(Rsp_Zero), .Rsp_Carry(Rsp_Carry), .Rsp_Err(Rsp_Err),
    .Alu_A(Alu_A), .Alu_B(Alu_B), .Alu_OpCode(Alu_OpCode),
    .Alu_Result(Alu_Result), .Alu_Zero(Alu_Zero), .Alu_Carry(Alu_Carry),
    .Busy(Busy)
  );

  // Reference ALU: add/sub/mul/div, Carry = add overflow out of 4 bits or
  // subtract borrow, unknown opcode and divide-by-zero give 0.
  always_comb begin
    Alu_Result = 8'd0;
    Alu_Carry  = 1'b0;
    case (Alu_OpCode)
      3'd0: begin
        Alu_Result = {4'd0, Alu_A} + {4'd0, Alu_B};
        Alu_Carry  = Alu_Result[4];
      end
      3'd1: begin
        Alu_Result = {4'd0, Alu_A} - {4'd0, Alu_B};
        Alu_Carry  = (Alu_A < Alu_B);
      end
      3'd2: Alu_Result = {4'd0, Alu_A} * {4'd0, Alu_B};
      3'd3: Alu_Result = (Alu_B == 4'd0) ? 8'd0 : {4'd0, Alu_A} / {4'd0, Alu_B};
      default: Alu_Result = 8'd0;
    endcase
    Alu_Zero = (Alu_Result == 8'd0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  typedef struct {
    logic [1:0] valid;
    logic [3:0] a0, b0; logic [2:0] op0;
    logic [3:0] a1, b1; logic [2:0] op1;
    logic       owner;
    logic [7:0] res;
    logic       zero, carry;
  } vec_t;

  function automatic vec_t mk(logic [1:0] v, logic [3:0] a0, logic [3:0] b0, logic [2:0] op0,
                              logic [3:0] a1, logic [3:0] b1, logic [2:0] op1,
                              logic own, logic [7:0] res, logic z, logic c);
    vec_t t;
    t.valid = v; t.a0 = a0; t.b0 = b0; t.op0 = op0;
    t.a1 = a1; t.b1 = b1; t.op1 = op1;
    t.owner = own; t.res = res; t.zero = z; t.carry = c;
    return t;
  endfunction

  // All steps start just after a falling edge; inputs stay applied through
  // the transaction, so tie vectors model requesters that stay valid.
  task automatic run_vec(input vec_t v, input int idx);
    logic [1:0] oh;
    string      tag;
    oh  = v.owner ? 2'b10 : 2'b01;
    tag = $sformatf("v%0d", idx);
    Req_Valid = v.valid;
    Req0_A = v.a0; Req0_B = v.b0; Req0_Op = v.op0;
    Req1_A = v.a1; Req1_B = v.b1; Req1_Op = v.op1;
    Rsp_Ready = 2'b00;
    #1;
    check({tag, " ready@N"}, 32'(Req_Ready), 32'(oh));
    check({tag, " busy@N"}, 32'(Busy), 32'd0);
    @(negedge clk); #1;
    check({tag, " ready/busy/rspv@N+1"}, 32'({Req_Ready, Busy, Rsp_Valid}), 32'({2'b00, 1'b1, 2'b00}));
    check({tag, " alu regs@N+1"}, 32'({Alu_A, Alu_B, Alu_OpCode}),
          v.owner ? 32'({v.a1, v.b1, v.op1}) : 32'({v.a0, v.b0, v.op0}));
    @(negedge clk); #1;
    check({tag, " rsp_valid@N+2"}, 32'(Rsp_Valid), 32'(oh));
    check({tag, " result"}, 32'(Rsp_Result), 32'(v.res));
    check({tag, " zero/carry/err"}, 32'({Rsp_Zero, Rsp_Carry, Rsp_Err}), 32'({v.zero, v.carry, 1'b0}));
    Rsp_Ready = oh;
    @(negedge clk); #1;
    check({tag, " idle@N+3"}, 32'({Busy, Rsp_Valid}), 32'd0);
    Rsp_Ready = 2'b00;
  endtask

  task automatic chk_reset(input string nm);
    check(nm, 32'({Req_Ready, Rsp_Valid, Busy, Alu_A, Alu_B, Alu_OpCode,
                   Rsp_Result, Rsp_Zero, Rsp_Carry, Rsp_Err}), 32'd0);
  endtask

  vec_t vecs[13];
  logic [10:0] alu_prev;

  initial begin
    vecs[0]  = mk(2'b11, 4'd7, 4'd2, 3'd1, 4'd4, 4'd3, 3'd2, 1'b0, 8'd5,   1'b0, 1'b0);
    vecs[1]  = mk(2'b11, 4'd7, 4'd2, 3'd1, 4'd4, 4'd3, 3'd2, 1'b1, 8'd12,  1'b0, 1'b0);
    vecs[2]  = mk(2'b11, 4'd7, 4'd2, 3'd1, 4'd4, 4'd3, 3'd2, 1'b0, 8'd5,   1'b0, 1'b0);
    vecs[3]  = mk(2'b11, 4'd7, 4'd2, 3'd1, 4'd4, 4'd3, 3'd2, 1'b1, 8'd12,  1'b0, 1'b0);
    vecs[4]  = mk(2'b01, 4'd15, 4'd1, 3'd0, 4'd0, 4'd0, 3'd0, 1'b0, 8'd16, 1'b0, 1'b1);
    vecs[5]  = mk(2'b01, 4'd9, 4'd0, 3'd3, 4'd0, 4'd0, 3'd0, 1'b0, 8'd0,   1'b1, 1'b0);
    vecs[6]  = mk(2'b10, 4'd1, 4'd1, 3'd0, 4'd3, 4'd5, 3'd0, 1'b1, 8'd8,   1'b0, 1'b0);
    vecs[7]  = mk(2'b10, 4'd1, 4'd1, 3'd0, 4'd2, 4'd3, 3'd0, 1'b1, 8'd5,   1'b0, 1'b0);
    vecs[8]  = mk(2'b01, 4'd3, 4'd5, 3'd0, 4'd9, 4'd9, 3'd0, 1'b0, 8'd8,   1'b0, 1'b0);
    vecs[9]  = mk(2'b01, 4'd2, 4'd5, 3'd1, 4'd0, 4'd0, 3'd0, 1'b0, 8'd253, 1'b0, 1'b1);
    vecs[10] = mk(2'b10, 4'd0, 4'd0, 3'd0, 4'd15, 4'd15, 3'd2, 1'b1, 8'd225, 1'b0, 1'b0);
    vecs[11] = mk(2'b01, 4'd13, 4'd4, 3'd3, 4'd0, 4'd0, 3'd0, 1'b0, 8'd3,  1'b0, 1'b0);
    vecs[12] = mk(2'b10, 4'd5, 4'd5, 3'd0, 4'd0, 4'd0, 3'd0, 1'b1, 8'd0,   1'b1, 1'b0);

    rst = 1'b1;
    Req_Valid = 2'b11; Rsp_Ready = 2'b00;
    Req0_A = 4'd1; Req0_B = 4'd1; Req0_Op = 3'd0;
    Req1_A = 4'd2; Req1_B = 4'd2; Req1_Op = 3'd0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset("reset state");
    rst = 1'b0; Req_Valid = 2'b00;

    // Table: contention from reset alternates 0,1,0,1, then lone requesters.
    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Response stalled for 5 cycles; the non-owner's Rsp_Ready is asserted.
    Req_Valid = 2'b01; Req0_A = 4'd3; Req0_B = 4'd5; Req0_Op = 3'd0;
    @(negedge clk);
    Req_Valid = 2'b10; Req1_A = 4'd1; Req1_B = 4'd1; Req1_Op = 3'd0;
    @(negedge clk);
    Rsp_Ready = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("stall c%0d valid/ready/busy", k), 32'({Rsp_Valid, Req_Ready, Busy}),
            32'({2'b01, 2'b00, 1'b1}));
      check($sformatf("stall c%0d payload", k), 32'({Rsp_Result, Rsp_Zero, Rsp_Carry}),
            32'({8'd8, 1'b0, 1'b0}));
      @(negedge clk);
    end
    Rsp_Ready = 2'b01; Req_Valid = 2'b00;
    @(negedge clk); #1;
    check("stall release idle", 32'({Busy, Rsp_Valid}), 32'd0);
    Rsp_Ready = 2'b00;

    // Reset during EXEC: requester 0 is in flight, so Last would favour 1.
    Req_Valid = 2'b01; Req0_A = 4'd7; Req0_B = 4'd6; Req0_Op = 3'd0;
    @(negedge clk);
    Req_Valid = 2'b11; rst = 1'b1;
    @(negedge clk); #1;
    chk_reset("rst in EXEC");
    rst = 1'b0; Req_Valid = 2'b00;
    @(negedge clk); #1;
    check("no rsp after EXEC rst", 32'({Rsp_Valid, Busy}), 32'd0);
    @(negedge clk);

    // Reset during RESP, then a tie must grant requester 0 again.
    Req_Valid = 2'b01; Req0_A = 4'd2; Req0_B = 4'd2; Req0_Op = 3'd2;
    @(negedge clk);
    Req_Valid = 2'b00;
    @(negedge clk); #1;
    check("pre-rst RESP valid", 32'(Rsp_Valid), 32'(2'b01));
    Req_Valid = 2'b11; rst = 1'b1;
    @(negedge clk); #1;
    chk_reset("rst in RESP");
    rst = 1'b0; Req_Valid = 2'b00;
    @(negedge clk); #1;
    check("no rsp after RESP rst", 32'({Rsp_Valid, Busy}), 32'd0);
    @(negedge clk);
    run_vec(vecs[0], 100);

    // Opcode outside the ALU's range.
    alu_prev = {Alu_A, Alu_B, Alu_OpCode};
    Req_Valid = 2'b01; Req0_A = 4'd6; Req0_B = 4'd2; Req0_Op = 3'd5;
    #1;
    check("op5 ready", 32'(Req_Ready), 32'(2'b01));
    @(negedge clk);
    Req_Valid = 2'b00;
    #1;
`ifdef ALU_ARB_OPCHK_EN
    check("op5 rsp_valid@N+1", 32'(Rsp_Valid), 32'(2'b01));
    check("op5 err payload", 32'({Rsp_Result, Rsp_Zero, Rsp_Carry, Rsp_Err}), 32'({8'd0, 3'b001}));
    check("op5 alu unchanged", 32'({Alu_A, Alu_B, Alu_OpCode}), 32'(alu_prev));
`else
    check("op5 rsp_valid@N+1", 32'(Rsp_Valid), 32'(2'b00));
    check("op5 alu loaded", 32'({Alu_A, Alu_B, Alu_OpCode}), 32'({4'd6, 4'd2, 3'd5}));
    @(negedge clk); #1;
    check("op5 rsp_valid@N+2", 32'(Rsp_Valid), 32'(2'b01));
    check("op5 payload", 32'({Rsp_Result, Rsp_Zero, Rsp_Carry, Rsp_Err}), 32'({8'd0, 3'b100}));
`endif
    Rsp_Ready = 2'b01;
    @(negedge clk); #1;
    check("op5 done idle", 32'({Busy, Rsp_Valid}), 32'd0);
    Rsp_Ready = 2'b00;
    // A legal opcode afterwards clears the error flag.
    run_vec(vecs[8], 101);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
